// File: rtl/arm32_cpu_pkg.sv
// arm32_cpu_pkg: shared types, flag indices and condition evaluation for the arm32_cpu core
package arm32_cpu_pkg;
  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } op_t;
  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_t;
  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_t;
  typedef enum logic [2:0] {RD_A, RD_B, EXEC, WB, DONE} state_t;
  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;
  // Odd codes are the negation of the even code below them; AL/NV fall out as 1/0.
  function automatic logic cond_pass(input cond_t c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[N_IDX];
    z = f[Z_IDX];
    cy = f[C_IDX];
    v = f[V_IDX];
    base = c[3:1] == 3'd0 ? z :
           c[3:1] == 3'd1 ? cy :
           c[3:1] == 3'd2 ? n :
           c[3:1] == 3'd3 ? v :
           c[3:1] == 3'd4 ? cy & ~z :
           c[3:1] == 3'd5 ? n == v :
           c[3:1] == 3'd6 ? ~z & (n == v) : 1'b1;
    return base ^ c[0];
  endfunction
endpackage

// File: rtl/arm32_cpu_barrel_shifter.sv
// arm32_cpu_barrel_shifter: operand2 shifter/rotator with ARM carry-out semantics
module arm32_cpu_barrel_shifter
  import arm32_cpu_pkg::*;
(
  input  logic [31:0] val_in,
  input  logic [7:0]  amt,
  input  shift_t      kind,
  input  logic        cin,
  output logic [31:0] val_out,
  output logic        cout
);
  logic [32:0] lsl, lsr, asr;
  logic [31:0] ror;
  // The extra bit on each side catches the last bit shifted out, giving the carry for free.
  always_comb begin
    lsl = {1'b0, val_in} << amt;
    lsr = {val_in, 1'b0} >> amt;
    asr = $signed({val_in, 1'b0}) >>> amt;
    ror = 32'({val_in, val_in} >> amt[4:0]);
    val_out = amt == 8'd0 ? val_in :
              kind == SH_LSL ? lsl[31:0] :
              kind == SH_LSR ? lsr[32:1] :
              kind == SH_ASR ? asr[32:1] : ror;
    cout = amt == 8'd0 ? cin :
           kind == SH_LSL ? lsl[32] :
           kind == SH_LSR ? lsr[0] :
           kind == SH_ASR ? asr[0] : ror[31];
  end
endmodule

// File: rtl/arm32_cpu.sv
// arm32_cpu: multicycle ARM data-processing core, one instruction per reset-started run
module arm32_cpu
  import arm32_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        waiting,
  output logic [31:0] status_out,
  output logic [31:0] datapath_out
);
  state_t state, state_nx;
  logic [31:0] rf [16];
  logic [3:0] status, nzcv, nzcv_q;
  logic [31:0] a, b, x, y, res, sh_src, sh_val;
  logic [7:0] sh_amt;
  logic [32:0] sum;
  logic sh_c, sh_cout, rev, inv, cin, arith, is_cmp, pass;
  shift_t sh_kind;
  op_t op;
  logic unused_bits;
  assign unused_bits = ^instr[27:26];
  assign op = op_t'(instr[24:21]);
  assign sh_src = instr[25] ? {24'b0, instr[7:0]} : rf[instr[3:0]];
  assign sh_amt = instr[25] ? {3'b0, instr[11:8], 1'b0} :
                  instr[4] ? rf[instr[11:8]][7:0] : {3'b0, instr[11:7]};
  assign sh_kind = instr[25] ? SH_ROR : shift_t'(instr[6:5]);
  arm32_cpu_barrel_shifter u_shift (
    .val_in(sh_src), .amt(sh_amt), .kind(sh_kind), .cin(status[C_IDX]),
    .val_out(sh_val), .cout(sh_cout)
  );
  // Reverse subtracts swap operands; all subtracts feed the adder an inverted second operand.
  always_comb begin
    rev = op == OP_RSB || op == OP_RSC;
    inv = op inside {OP_SUB, OP_RSB, OP_SBC, OP_RSC, OP_CMP};
    arith = op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
    is_cmp = op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    x = rev ? b : a;
    y = inv ? ~(rev ? a : b) : b;
    cin = op inside {OP_ADC, OP_SBC, OP_RSC} ? status[C_IDX] : op inside {OP_SUB, OP_RSB, OP_CMP};
    sum = {1'b0, x} + {1'b0, y} + 33'(cin);
    res = arith ? sum[31:0] :
          op inside {OP_AND, OP_TST} ? a & b :
          op inside {OP_EOR, OP_TEQ} ? a ^ b :
          op == OP_ORR ? a | b :
          op == OP_MOV ? b :
          op == OP_BIC ? a & ~b : ~b;
    nzcv = {res[31], res == 32'd0, arith ? sum[32] : sh_c,
            arith ? (x[31] == y[31]) && (sum[31] != x[31]) : status[V_IDX]};
    pass = cond_pass(cond_t'(instr[31:28]), status);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RD_A;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state != DONE) state_nx = state_t'(state + 3'd1);
  end
  always_ff @(posedge clk) begin
    if (state == RD_A) a <= rf[instr[19:16]];
    if (state == RD_B) begin
      b <= sh_val;
      sh_c <= sh_cout;
    end
    if (state == EXEC) begin
      datapath_out <= res;
      nzcv_q <= nzcv;
    end
    if (state == WB && pass) begin
      if (!is_cmp) rf[instr[15:12]] <= datapath_out;
      if (instr[20] || is_cmp) status <= nzcv_q;
    end
  end
  assign waiting = state == DONE;
  assign status_out = {status, 28'b0};
endmodule

// File: tb/tb_arm32_cpu.sv
// tb_arm32_cpu: directed vector bench for arm32_cpu, plus mid-run reset sequences
module tb_arm32_cpu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic waiting;
  logic [31:0] status_out, datapath_out;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] dp;
    logic [31:0] st;
  } vec_t;
  vec_t v[$];

  arm32_cpu dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .waiting(waiting), .status_out(status_out), .datapath_out(datapath_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", name, what, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] ins, input int edges);
    @(negedge clk);
    instr = ins;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (edges) @(posedge clk);
    #1;
  endtask

  initial begin
    v.push_back('{"mov_r0",     32'hE3A00001, 32'd1,        32'h00000000});
    v.push_back('{"mov_r1",     32'hE3A01002, 32'd2,        32'h00000000});
    v.push_back('{"mov_r2",     32'hE3A02003, 32'd3,        32'h00000000});
    v.push_back('{"mov_r3",     32'hE3A03004, 32'd4,        32'h00000000});
    v.push_back('{"adds",       32'hE0900000, 32'd2,        32'h00000000});
    v.push_back('{"addeq_fail", 32'h02811008, 32'd10,       32'h00000000});
    v.push_back('{"add_lsl_rs", 32'hE0811210, 32'd18,       32'h00000000});
    v.push_back('{"subs_zero",  32'hE0504000, 32'd0,        32'h60000000});
    v.push_back('{"movs_rot",   32'hE3B05102, 32'h80000000, 32'hA0000000});
    v.push_back('{"mov_lsr2",   32'hE1A07121, 32'd4,        32'hA0000000});
    v.push_back('{"cmp_eq",     32'hE3510012, 32'd0,        32'h60000000});
    v.push_back('{"moveq_pass", 32'h03A08005, 32'd5,        32'h60000000});
    v.push_back('{"mvn_imm",    32'hE3E0A102, 32'h7FFFFFFF, 32'h60000000});
    v.push_back('{"adds_ovf",   32'hE29AB001, 32'h80000000, 32'h90000000});
    v.push_back('{"movs_asr4",  32'hE1B0C24B, 32'hF8000000, 32'h90000000});
    v.push_back('{"adcs_c0",    32'hE2B1D000, 32'd18,       32'h00000000});
    v.push_back('{"mov_r14_32", 32'hE3A0E020, 32'd32,       32'h00000000});
    v.push_back('{"movs_lsl32", 32'hE1B09E1A, 32'd0,        32'h60000000});
    v.push_back('{"rsbs",       32'hE2715014, 32'd2,        32'h20000000});
    v.push_back('{"mov_nv",     32'hF3A0E0FF, 32'd255,      32'h20000000});
    v.push_back('{"rd_r14",     32'hE1A0600E, 32'd32,       32'h20000000});
    v.push_back('{"rd_r8",      32'hE1A06008, 32'd5,        32'h20000000});

    repeat (3) @(posedge clk);
    #1;
    chk("reset", "waiting", {31'b0, waiting}, 32'd0);
    chk("reset", "status", status_out, 32'd0);

    foreach (v[i]) begin
      start(v[i].ins, 3);
      chk(v[i].name, "early_waiting", {31'b0, waiting}, 32'd0);
      @(posedge clk);
      #1;
      chk(v[i].name, "waiting", {31'b0, waiting}, 32'd1);
      chk(v[i].name, "datapath", datapath_out, v[i].dp);
      chk(v[i].name, "status", status_out, v[i].st);
    end

    // Abort ADD R0,R0,R0 after two edges: nothing committed, datapath holds.
    start(32'hE0800000, 2);
    rst_n = 1'b0;
    #2;
    chk("abort2", "waiting", {31'b0, waiting}, 32'd0);
    chk("abort2", "datapath", datapath_out, 32'd5);
    start(32'hE0800000, 4);
    chk("rerun", "waiting", {31'b0, waiting}, 32'd1);
    chk("rerun", "datapath", datapath_out, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", "waiting", {31'b0, waiting}, 32'd1);
    chk("done_hold", "datapath", datapath_out, 32'd4);
    start(32'hE1A06000, 4);
    chk("rd_r0_a", "datapath", datapath_out, 32'd4);

    // Abort in WB: datapath already shows the result but R0 must not change.
    start(32'hE0800000, 3);
    chk("abort3", "datapath", datapath_out, 32'd8);
    rst_n = 1'b0;
    #2;
    chk("abort3", "waiting", {31'b0, waiting}, 32'd0);
    start(32'hE1A06000, 4);
    chk("rd_r0_b", "datapath", datapath_out, 32'd4);
    chk("rd_r0_b", "status", status_out, 32'h20000000);
    start(32'hE0800000, 4);
    chk("final_add", "datapath", datapath_out, 32'd8);
    chk("final_add", "waiting", {31'b0, waiting}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
